// File: rtl/dotprod_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : dotprod_feeder_if
//  Description : Bundle of the stream-in, engine memory-read, engine control
//                and result-out signals of the dot-product feeder.
//                slave  = feeder side, master = environment side.
//  Revision    : 1.0  initial release
// ============================================================================
interface dotprod_feeder_if;
    // input stream of vector pairs
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_a;
    logic [31:0] s_b;
    logic        s_last;
    // engine memory read ports
    logic [31:0] a_address0;
    logic        a_ce0;
    logic [31:0] a_q0;
    logic [31:0] b_address0;
    logic        b_ce0;
    logic [31:0] b_q0;
    // engine control
    logic [31:0] n;
    logic        ap_start;
    logic        ap_done;
    logic [31:0] ap_return;
    // result out
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_err;

    modport slave (
        input  s_valid, s_a, s_b, s_last,
        output s_ready,
        input  a_address0, a_ce0, b_address0, b_ce0,
        output a_q0, b_q0,
        output n, ap_start,
        input  ap_done, ap_return,
        output res_valid, res_data, res_err,
        input  res_ready
    );

    modport master (
        output s_valid, s_a, s_b, s_last,
        input  s_ready,
        output a_address0, a_ce0, b_address0, b_ce0,
        input  a_q0, b_q0,
        input  n, ap_start,
        output ap_done, ap_return,
        input  res_valid, res_data, res_err,
        output res_ready
    );
endinterface
`default_nettype wire

// File: rtl/dotprod_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : dotprod_feeder
//  Description : Buffers a streamed pair of vectors, exposes them to a
//                dot-product engine through two 1-cycle-latency read ports,
//                starts the engine and hands its result downstream.
//                Optional RUN watchdog: define DOTPROD_FEEDER_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module dotprod_feeder #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned TIMEOUT = 4096
) (
    input  wire logic       ap_clk,
    input  wire logic       ap_rst,
    dotprod_feeder_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    // Refuse to elaborate with a capacity that the wrap-around pointer or
    // the watchdog compare cannot represent.
    if ((DEPTH < 2) || (DEPTH > 1024) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (TIMEOUT < 1)) begin : g_bad_params
        $error("dotprod_feeder: illegal DEPTH or TIMEOUT");
    end

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        START  = 2'd1,
        RUN    = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [31:0]   n_q, n_d;
    logic [31:0]   res_data_q, res_data_d;
    logic [31:0]   a_q_q, b_q_q;
    logic [31:0]   buf_a [DEPTH];
    logic [31:0]   buf_b [DEPTH];

    logic w_busy, w_accept, w_last_beat, w_done, w_take, w_timeout;

`ifdef DOTPROD_FEEDER_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);
    logic [31:0] cnt_q;
    logic        res_err_q, res_err_d;

    // Watchdog: cleared as START is entered, counts every START/RUN cycle.
    always_ff @(posedge ap_clk) begin
        if (ap_rst)           cnt_q <= '0;
        else if (w_last_beat) cnt_q <= '0;
        else if (w_busy)      cnt_q <= cnt_q + 32'd1;
    end

    // Fires on the TIMEOUT-th START/RUN cycle unless the engine finishes then.
    assign w_timeout   = w_busy && (cnt_q == TIMEOUT_LAST) && !bus.ap_done;
    assign bus.res_err = res_err_q;
`else
    assign w_timeout   = 1'b0;
    assign bus.res_err = 1'b0;
`endif

    // Next-state and datapath-update decode; ap_done/res_ready only matter
    // in the states that consume them.
    always_comb begin
        w_busy      = (state_q == START) || (state_q == RUN);
        w_accept    = (state_q == LOAD) && bus.s_valid;
        w_last_beat = w_accept && (bus.s_last || (wptr_q == AW'(DEPTH - 1)));
        w_done      = w_busy && bus.ap_done;
        w_take      = (state_q == RESULT) && bus.res_ready;

        state_d    = state_q;
        wptr_d     = wptr_q;
        n_d        = n_q;
        res_data_d = res_data_q;
`ifdef DOTPROD_FEEDER_TIMEOUT_EN
        res_err_d  = res_err_q;
`endif
        case (state_q)
            LOAD: begin
                if (w_accept) wptr_d = wptr_q + 1'b1;
                if (w_last_beat) begin
                    n_d     = 32'(wptr_q) + 32'd1;
                    state_d = START;
                end
            end
            START, RUN: begin
                if (state_q == START) state_d = RUN;
                if (w_done) begin
                    res_data_d = bus.ap_return;
`ifdef DOTPROD_FEEDER_TIMEOUT_EN
                    res_err_d  = 1'b0;
`endif
                    state_d    = RESULT;
                end else if (w_timeout) begin
                    res_data_d = 32'hDEADBEEF;
`ifdef DOTPROD_FEEDER_TIMEOUT_EN
                    res_err_d  = 1'b1;
`endif
                    state_d    = RESULT;
                end
            end
            RESULT: begin
                if (w_take) begin
                    wptr_d  = '0;
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // State and control registers.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= LOAD;
            wptr_q     <= '0;
            n_q        <= '0;
            res_data_q <= '0;
`ifdef DOTPROD_FEEDER_TIMEOUT_EN
            res_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            n_q        <= n_d;
            res_data_q <= res_data_d;
`ifdef DOTPROD_FEEDER_TIMEOUT_EN
            res_err_q  <= res_err_d;
`endif
        end
    end

    // Vector storage: no reset so it maps onto RAM; survives ap_rst.
    always_ff @(posedge ap_clk) begin
        if (w_accept) begin
            buf_a[wptr_q] <= bus.s_a;
            buf_b[wptr_q] <= bus.s_b;
        end
    end

    // Engine read ports: registered, zero beyond n, hold when not enabled.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            a_q_q <= '0;
            b_q_q <= '0;
        end else begin
            if (bus.a_ce0)
                a_q_q <= (bus.a_address0 >= n_q) ? 32'd0 : buf_a[bus.a_address0[AW-1:0]];
            if (bus.b_ce0)
                b_q_q <= (bus.b_address0 >= n_q) ? 32'd0 : buf_b[bus.b_address0[AW-1:0]];
        end
    end

    assign bus.s_ready   = (state_q == LOAD);
    assign bus.ap_start  = w_busy;
    assign bus.res_valid = (state_q == RESULT);
    assign bus.res_data  = res_data_q;
    assign bus.n         = n_q;
    assign bus.a_q0      = a_q_q;
    assign bus.b_q0      = b_q_q;

endmodule
`default_nettype wire

// File: tb/tb_dotprod_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dotprod_feeder
//  Description : Directed self-checking bench for dotprod_feeder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dotprod_feeder;
    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    dotprod_feeder_if u_if ();

    dotprod_feeder #(.DEPTH(64), .TIMEOUT(16)) u_dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (u_if)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic last);
        u_if.s_valid = 1'b1;
        u_if.s_a     = a;
        u_if.s_b     = b;
        u_if.s_last  = last;
        tick();
        u_if.s_valid = 1'b0;
        u_if.s_last  = 1'b0;
    endtask

    initial begin
        int waited;
        u_if.s_valid = 0; u_if.s_a = 0; u_if.s_b = 0; u_if.s_last = 0;
        u_if.a_address0 = 0; u_if.a_ce0 = 0; u_if.b_address0 = 0; u_if.b_ce0 = 0;
        u_if.ap_done = 0; u_if.ap_return = 0; u_if.res_ready = 0;

        // reset state
        tick(); tick();
        ap_rst = 1'b0;
        chk("rst_s_ready",   32'(u_if.s_ready),   32'd1);
        chk("rst_ap_start",  32'(u_if.ap_start),  32'd0);
        chk("rst_res_valid", 32'(u_if.res_valid), 32'd0);
        chk("rst_n",         u_if.n,              32'd0);
        chk("rst_res_data",  u_if.res_data,       32'd0);
        chk("rst_res_err",   32'(u_if.res_err),   32'd0);
        chk("rst_a_q0",      u_if.a_q0,           32'd0);
        chk("rst_b_q0",      u_if.b_q0,           32'd0);

        // three-beat load ending on s_last
        beat(32'd1, 32'd4, 1'b0);
        beat(32'd2, 32'd5, 1'b0);
        beat(32'd3, 32'd6, 1'b1);
        chk("load3_n",        u_if.n,              32'd3);
        chk("load3_ap_start", 32'(u_if.ap_start),  32'd1);
        chk("load3_s_ready",  32'(u_if.s_ready),   32'd0);

        // reads: a[1]=2, b address 5 beyond n -> 0
        u_if.a_ce0 = 1; u_if.a_address0 = 1;
        u_if.b_ce0 = 1; u_if.b_address0 = 5;
        tick();
        chk("rd_a1",     u_if.a_q0, 32'd2);
        chk("rd_b5_oob", u_if.b_q0, 32'd0);
        u_if.a_ce0 = 0; u_if.a_address0 = 0;
        u_if.b_address0 = 2;
        tick();
        chk("rd_b2",     u_if.b_q0, 32'd6);
        chk("rd_a_hold", u_if.a_q0, 32'd2);
        u_if.b_ce0 = 0;

        // engine done with result 32, consumer stalls 4 cycles
        u_if.ap_done = 1; u_if.ap_return = 32'd32;
        tick();
        u_if.ap_done = 0; u_if.ap_return = 32'd0;
        for (int i = 0; i < 4; i++) begin
            chk("stall_res_valid", 32'(u_if.res_valid), 32'd1);
            chk("stall_res_data",  u_if.res_data,       32'd32);
            chk("stall_s_ready",   32'(u_if.s_ready),   32'd0);
            chk("stall_ap_start",  32'(u_if.ap_start),  32'd0);
            tick();
        end
        u_if.res_ready = 1;
        tick();
        u_if.res_ready = 0;
        chk("take_s_ready",  32'(u_if.s_ready),   32'd1);
        chk("take_res_valid",32'(u_if.res_valid), 32'd0);

        // ap_done while loading is ignored
        u_if.ap_done = 1; u_if.ap_return = 32'd99;
        tick();
        u_if.ap_done = 0; u_if.ap_return = 0;
        chk("ign_done_res_data", u_if.res_data,      32'd32);
        chk("ign_done_s_ready",  32'(u_if.s_ready),  32'd1);

        // forced end after DEPTH beats without s_last
        for (int i = 0; i < 64; i++) begin
            u_if.s_valid = 1; u_if.s_last = 0;
            u_if.s_a = 32'(100 + i); u_if.s_b = 32'(200 + i);
            tick();
        end
        chk("full_n",        u_if.n,             32'd64);
        chk("full_ap_start", 32'(u_if.ap_start), 32'd1);
        chk("full_s_ready",  32'(u_if.s_ready),  32'd0);
        u_if.s_a = 32'd999; u_if.s_b = 32'd999;
        tick();
        u_if.s_valid = 0;
        u_if.a_ce0 = 1; u_if.a_address0 = 63;
        u_if.b_ce0 = 1; u_if.b_address0 = 0;
        tick();
        chk("full_a63", u_if.a_q0, 32'd163);
        chk("full_b0",  u_if.b_q0, 32'd200);
        u_if.a_address0 = 0; u_if.b_address0 = 64;
        tick();
        chk("no_beat65_a0", u_if.a_q0, 32'd100);
        chk("full_b64_oob", u_if.b_q0, 32'd0);
        u_if.a_ce0 = 0; u_if.b_ce0 = 0;

        // reset while RUN
        ap_rst = 1;
        tick();
        ap_rst = 0;
        chk("runrst_ap_start",  32'(u_if.ap_start),  32'd0);
        chk("runrst_res_valid", 32'(u_if.res_valid), 32'd0);
        chk("runrst_s_ready",   32'(u_if.s_ready),   32'd1);
        chk("runrst_n",         u_if.n,              32'd0);
        chk("runrst_a_q0",      u_if.a_q0,           32'd0);

        // two beats, ap_done arriving in START
        beat(32'd7, 32'd9, 1'b0);
        beat(32'd8, 32'd10, 1'b1);
        chk("two_n", u_if.n, 32'd2);
        u_if.ap_done = 1; u_if.ap_return = 32'd77;
        u_if.a_ce0 = 1; u_if.a_address0 = 1;
        tick();
        u_if.ap_done = 0; u_if.ap_return = 0; u_if.a_ce0 = 0;
        chk("start_done_res_valid", 32'(u_if.res_valid), 32'd1);
        chk("start_done_res_data",  u_if.res_data,       32'd77);
        chk("two_a1",               u_if.a_q0,           32'd8);
        u_if.res_ready = 1;
        tick();
        u_if.res_ready = 0;
        chk("two_back_load", 32'(u_if.s_ready), 32'd1);

        // engine never finishes
        beat(32'd5, 32'd6, 1'b1);
        waited = 0;
`ifdef DOTPROD_FEEDER_TIMEOUT_EN
        while (u_if.res_valid !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        chk("to_cycles",    32'(waited),         32'd16);
        chk("to_res_valid", 32'(u_if.res_valid), 32'd1);
        chk("to_res_err",   32'(u_if.res_err),   32'd1);
        chk("to_res_data",  u_if.res_data,       32'hDEADBEEF);
        chk("to_ap_start",  32'(u_if.ap_start),  32'd0);
`else
        while (waited < 40) begin
            tick();
            waited++;
        end
        chk("nto_res_valid", 32'(u_if.res_valid), 32'd0);
        chk("nto_ap_start",  32'(u_if.ap_start),  32'd1);
        chk("nto_res_err",   32'(u_if.res_err),   32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
